// File: rtl/arc4_sched.sv
// ARC4 start-up scheduler: runs the init engine and then the key-schedule engine,
// and routes whichever engine is active onto the shared 256x8 S memory port.
module arc4_sched (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic       init_en,
  input  logic       init_rdy,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_wrdata,
  input  logic       init_wren,
  output logic       ksa_en,
  input  logic       ksa_rdy,
  input  logic [7:0] ksa_addr,
  input  logic [7:0] ksa_wrdata,
  input  logic       ksa_wren,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [1:0] phase
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_START,
    S_INIT_WAIT,
    S_KSA_START,
    S_KSA_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INIT,
    OWN_KSA
  } owner_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_busy_seen;
  logic       w_busy_next;
  logic [1:0] r_phase;
  owner_t     w_owner;

  function automatic logic [1:0] phase_of(input state_t s);
    logic [1:0] p;
    case (s)
      S_INIT_START, S_INIT_WAIT: p = 2'b01;
      S_KSA_START,  S_KSA_WAIT:  p = 2'b10;
      S_DONE:                    p = 2'b11;
      default:                   p = 2'b00;
    endcase
    return p;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy_seen <= 1'b0;
      r_phase     <= 2'b00;
    end else begin
      r_state     <= w_next;
      r_busy_seen <= w_busy_next;
      // Registered from the next state so phase lines up with the state it names.
      r_phase     <= phase_of(w_next);
    end
  end

  // busy_seen is only kept alive while staying in a WAIT state, so every
  // entry into a WAIT state starts from zero.
  always_comb begin
    w_next      = r_state;
    w_busy_next = 1'b0;
    rdy         = 1'b0;
    init_en     = 1'b0;
    ksa_en      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        rdy = 1'b1;
        if (en) w_next = S_INIT_START;
      end
      S_INIT_START: begin
        init_en = init_rdy;
        if (init_rdy) w_next = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (r_busy_seen && init_rdy) w_next = S_KSA_START;
        else w_busy_next = r_busy_seen | ~init_rdy;
      end
      S_KSA_START: begin
        ksa_en = ksa_rdy;
        if (ksa_rdy) w_next = S_KSA_WAIT;
      end
      S_KSA_WAIT: begin
        if (r_busy_seen && ksa_rdy) w_next = S_DONE;
        else w_busy_next = r_busy_seen | ~ksa_rdy;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (r_state)
      S_INIT_START, S_INIT_WAIT: w_owner = OWN_INIT;
      S_KSA_START,  S_KSA_WAIT:  w_owner = OWN_KSA;
      default:                   w_owner = OWN_NONE;
    endcase
  end

  // Zero-latency memory mux; a non-owner's write enable never reaches the memory.
  always_comb begin
    s_addr   = 8'h00;
    s_wrdata = 8'h00;
    s_wren   = 1'b0;
    case (w_owner)
      OWN_INIT: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      OWN_KSA: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      default: begin
        s_addr   = 8'h00;
        s_wrdata = 8'h00;
        s_wren   = 1'b0;
      end
    endcase
  end

  assign phase = r_phase;

endmodule

// File: doc/arc4_sched.md
ARC4_SCHED -- requirements
Module: arc4_sched

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single system clock; all state on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 en  in  1  start request; sampled only while rdy=1.
REQ-005 rdy  out  1  high = idle, can accept en.
REQ-006 init_en  out  1  one-cycle start pulse to init engine.
REQ-007 init_rdy  in  1  init engine ready/idle.
REQ-008 init_addr, init_wrdata  in  8 each  init engine S-memory address/write data.
REQ-009 init_wren  in  1  init engine write enable.
REQ-010 ksa_en  out  1  one-cycle start pulse to key-schedule engine.
REQ-011 ksa_rdy  in  1  key-schedule engine ready/idle.
REQ-012 ksa_addr, ksa_wrdata  in  8 each  key-schedule S-memory address/write data.
REQ-013 ksa_wren  in  1  key-schedule write enable.
REQ-014 s_addr, s_wrdata  out  8 each  to shared 256x8 S memory.
REQ-015 s_wren  out  1  to shared S memory.
REQ-016 phase  out  2  status: 00 idle, 01 init, 10 ksa, 11 done.

Function
REQ-017 FSM states: IDLE, INIT_START, INIT_WAIT, KSA_START, KSA_WAIT, DONE.
REQ-018 rdy=1 only in IDLE and DONE; en=1 there -> INIT_START next edge; en ignored in all other states.
REQ-019 INIT_START: init_en = init_rdy (combinational); if init_rdy=1 -> INIT_WAIT next edge, else hold with init_en=0.
REQ-020 *_WAIT: registered busy_seen flag cleared on entry, set when engine rdy=0; completion = busy_seen=1 and engine rdy=1.
REQ-021 INIT_WAIT completion -> KSA_START; KSA_START mirrors REQ-019 using ksa_en/ksa_rdy -> KSA_WAIT.
REQ-022 KSA_WAIT completion -> DONE; DONE holds until en=1, which restarts at INIT_START.
REQ-023 Each *_en asserts for exactly one cycle per run; never both in the same cycle.
REQ-024 Memory owner: init in INIT_START/INIT_WAIT, ksa in KSA_START/KSA_WAIT, none otherwise.
REQ-025 s_addr/s_wrdata/s_wren = owner's signals combinationally, zero latency; non-owner wren ignored.
REQ-026 No owner: s_addr=0x00, s_wrdata=0x00, s_wren=0.
REQ-027 phase: 00 in IDLE, 01 in INIT_*, 10 in KSA_*, 11 in DONE; registered from state.
REQ-028 Engine rdy glitch high in *_WAIT before busy_seen set: not completion; hold.

Reset
REQ-029 rst_n=0 -> immediately state IDLE, busy_seen=0, rdy=1, init_en=0, ksa_en=0, s_wren=0, s_addr=0x00, s_wrdata=0x00, phase=00.
REQ-030 Reset mid-operation aborts run; no *_en pulse until next en after rst_n=1; first edge after release is IDLE behaviour.

Verification
REQ-031 Reset: rst_n=0 at any state -> same cycle rdy=1, s_wren=0, phase=00, init_en=ksa_en=0.
REQ-032 Full run: en pulse at cycle 0, engine models drop rdy 1 cycle after en, stay low 256 cycles -> init_en single pulse cycle 1, ksa_en single pulse 1 cycle after init_rdy returns, phase 01->10->11, rdy=1 after ksa_rdy returns.
REQ-033 Mux: INIT phase with init_addr=0x2A, init_wrdata=0x2A, init_wren=1, ksa_addr=0x55, ksa_wren=1 -> s_addr=0x2A, s_wren=1; KSA phase swapped -> s_addr=0x55; DONE -> s_wren=0, s_addr=0x00.
REQ-034 Handshake: init_rdy=0 for 5 cycles in INIT_START -> init_en=0 those cycles, pulses on first init_rdy=1; en=1 while rdy=0 -> no effect.
REQ-035 Abort: rst_n low 2 cycles mid-KSA_WAIT -> rdy=1, phase=00, no ksa_en; subsequent en runs full sequence.
REQ-036 Rerun: en in DONE -> INIT_START, phase 01, init_en pulse again.
